emio_master: RTL and testbench

Initiator for the EMIO register-bus handshake. It drives the processor-facing EMIO vectors (`emio_ps_out`, `emio_ps_tri`) and consumes `emio_ps_in`, so PL logic can issue quadlet reads, quadlet writes and block writes with the same signalling the PS uses. It also serves as the bench driver for the FPGA-side EMIO responder. Commands come from a local valid/ready port and results return on a one-cycle response strobe.

---
 rtl/emio_master.sv | 251 +++++++++++++++++++++++++
 tb/tb_emio_master.sv | 494 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/emio_master.sv
// emio_master: PL-side initiator for the EMIO register-bus handshake.
//
// Issues quadlet reads, quadlet writes and (optionally) block writes on the
// processor-facing EMIO vectors, using the same req/done signalling as the PS.
//
// Optional feature macro: EMIO_MASTER_BLKWR_EN enables block writes. When it is
// undefined, cmd_blk_first/cmd_blk_last are ignored and emio_ps_out[52:51] are
// held at 0.
//
// Parameters:
//   SETUP_CYCLES   cycles addr/wdata/tri are held before req_bus or enables rise
//   TIMEOUT_CYCLES wait limit for each done-edge wait (16-bit counter)
//
// Ports:
//   sysclk, reset        clock, synchronous active-high reset
//   cmd_valid/cmd_ready  command handshake
//   cmd_write            1 = write, 0 = read
//   cmd_addr, cmd_wdata  register address and write data
//   cmd_blk_first/last   block-write word markers
//   rsp_valid            one-cycle completion strobe
//   rsp_rdata, rsp_err   read data and error flag, valid with rsp_valid
//   emio_ps_out          [31:0] wdata, [47:32] addr, [48] req_bus, [50] reg_wen,
//                        [51] blk_wstart, [52] blk_wen
//   emio_ps_tri          [31:0] all 1s for a read, 0 for a write
//   emio_ps_in           [31:0] read data, [49] done, [54] grant
module emio_master #(
    parameter int unsigned SETUP_CYCLES   = 2,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [15:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic        cmd_blk_first,
    input  logic        cmd_blk_last,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [63:0] emio_ps_out,
    output logic [63:0] emio_ps_tri,
    input  logic [63:0] emio_ps_in
);

`ifdef EMIO_MASTER_BLKWR_EN
    localparam logic BlkEn = 1'b1;
`else
    localparam logic BlkEn = 1'b0;
`endif

    localparam logic [15:0] SetupLast = 16'(SETUP_CYCLES);
    localparam logic [15:0] ToLast    = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StReq,
        StRelease,
        StResp,
        StBlkHold,
        StBlkWord
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rd_q, rd_d;
    logic        write_q, write_d;
    logic        first_q, first_d;
    logic        last_q, last_d;
    logic        blk_q, blk_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    // Holds cmd_ready low until the first cycle after reset deasserts.
    logic        live_q;

    logic done_meta, done_s;
    logic grant_meta, grant_s;

    logic req_bus, reg_wen, blk_wstart, blk_wen;
    logic first_req;
    logic timeout;

    // grant is synchronised for observability but not used by the sequencer.
    logic unused_in;
    assign unused_in = ^{emio_ps_in[63:55], emio_ps_in[53:50], emio_ps_in[48:32], grant_s};

    always_ff @(posedge sysclk) begin
        if (reset) begin
            done_meta  <= 1'b0;
            done_s     <= 1'b0;
            grant_meta <= 1'b0;
            grant_s    <= 1'b0;
        end else begin
            done_meta  <= emio_ps_in[49];
            done_s     <= done_meta;
            grant_meta <= emio_ps_in[54];
            grant_s    <= grant_meta;
        end
    end

    assign timeout = (cnt_q == ToLast);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        write_d = write_q;
        first_d = first_q;
        last_d  = last_q;
        blk_d   = blk_q;
        err_d   = err_q;
        rdata_d = rdata_q;

        unique case (state_q)
            StIdle: begin
                err_d = 1'b0;
                if (cmd_valid && live_q) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    rd_d    = ~cmd_write;
                    write_d = cmd_write;
                    first_d = BlkEn & cmd_write & cmd_blk_first;
                    last_d  = BlkEn & cmd_write & cmd_blk_last;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                if (cnt_q == SetupLast) begin
                    state_d = blk_q ? StBlkWord : StReq;
                end
            end
            StReq: begin
                if (done_s) begin
                    if (!write_q) begin
                        rdata_d = emio_ps_in[31:0];
                    end
                    // The first word opens the block: req_bus and blk_wstart stay up.
                    if (first_q) begin
                        blk_d = 1'b1;
                    end
                    state_d = StRelease;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = StRelease;
                end
            end
            StBlkWord: begin
                if (done_s) begin
                    state_d = StRelease;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    blk_d   = 1'b0;
                    state_d = StRelease;
                end
            end
            StRelease: begin
                if (!done_s) begin
                    if (last_q) begin
                        blk_d = 1'b0;
                    end
                    state_d = StResp;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    blk_d   = 1'b0;
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = blk_q ? StBlkHold : StIdle;
            end
            StBlkHold: begin
                err_d = 1'b0;
                if (cmd_valid) begin
                    if (!cmd_write || cmd_blk_first) begin
                        // Consumed but not issued; bus outputs stay untouched.
                        err_d   = 1'b1;
                        state_d = StResp;
                    end else begin
                        addr_d  = cmd_addr;
                        wdata_d = cmd_wdata;
                        rd_d    = 1'b0;
                        write_d = 1'b1;
                        first_d = 1'b0;
                        last_d  = cmd_blk_last;
                        state_d = StSetup;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b1;
            write_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            blk_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            write_q <= write_d;
            first_q <= first_d;
            last_q  <= last_d;
            blk_q   <= blk_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            live_q  <= 1'b1;
        end
    end

    always_comb begin
        first_req  = (state_q == StReq) && write_q && first_q;
        req_bus    = (state_q == StReq) || (state_q == StBlkWord) || blk_q;
        reg_wen    = write_q && ((state_q == StReq) || (state_q == StBlkWord));
        blk_wen    = BlkEn && (first_req || (state_q == StBlkWord));
        blk_wstart = BlkEn && (first_req || blk_q);

        emio_ps_out = {11'b0, blk_wen, blk_wstart, reg_wen, 1'b0, req_bus, addr_q, wdata_q};
        emio_ps_tri = {32'h0, {32{rd_q}}};

        cmd_ready = live_q && ((state_q == StIdle) || (state_q == StBlkHold));
        rsp_valid = (state_q == StResp);
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
    end

endmodule

// File: tb/tb_emio_master.sv
module tb_emio_master;

    localparam int unsigned SetupCycles   = 2;
    localparam int unsigned TimeoutCycles = 64;

    logic        sysclk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        cmd_blk_first;
    logic        cmd_blk_last;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [63:0] emio_ps_out;
    logic [63:0] emio_ps_tri;
    logic [63:0] emio_ps_in;

    emio_master #(
        .SETUP_CYCLES  (SetupCycles),
        .TIMEOUT_CYCLES(TimeoutCycles)
    ) dut (
        .sysclk       (sysclk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .cmd_blk_first(cmd_blk_first),
        .cmd_blk_last (cmd_blk_last),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .emio_ps_out  (emio_ps_out),
        .emio_ps_tri  (emio_ps_tri),
        .emio_ps_in   (emio_ps_in)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    logic req_bus, reg_wen, blk_wen;
    assign req_bus = emio_ps_out[48];
    assign reg_wen = emio_ps_out[50];
    assign blk_wen = emio_ps_out[52];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        bit          chk_data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Responder model controls
    bit          resp_enable = 1'b1;
    int          resp_delay  = 2;
    logic [31:0] resp_data   = '0;

    // Captured response
    logic [31:0] got_rdata;
    logic        got_err;

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    // Responder: answers reg_wen, or a read request, with done after resp_delay cycles.
    initial begin : responder
        int  rs;
        int  dly;
        bit  act;
        rs = 0;
        dly = 0;
        emio_ps_in = '0;
        emio_ps_in[54] = 1'b1;
        forever begin
            @(posedge sysclk);
            #1;
            act = reg_wen || (req_bus && emio_ps_tri[0]);
            case (rs)
                0: if (act && resp_enable) begin
                    dly = resp_delay;
                    rs  = 1;
                end
                1: if (dly == 0) begin
                    emio_ps_in[31:0] = resp_data;
                    emio_ps_in[49]   = 1'b1;
                    rs = 2;
                end else begin
                    dly--;
                end
                default: if (!act) begin
                    emio_ps_in[49]   = 1'b0;
                    emio_ps_in[31:0] = '0;
                    rs = 0;
                end
            endcase
        end
    end

    // Offers a command and returns right after the accepting edge.
    task automatic send_cmd(input bit wr, input logic [15:0] addr, input logic [31:0] data,
                            input bit first, input bit last);
        bit done;
        done = 1'b0;
        cmd_write     = wr;
        cmd_addr      = addr;
        cmd_wdata     = data;
        cmd_blk_first = first;
        cmd_blk_last  = last;
        cmd_valid     = 1'b1;
        for (int i = 0; i < 300 && !done; i++) begin
            if (cmd_ready) done = 1'b1;
            tick();
        end
        cmd_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL cmd_accept got no accept want accept within 300 cycles");
        end
    endtask

    // Waits (bounded) for rsp_valid; leaves the bench at the sample where it is high.
    task automatic wait_rsp(output bit got);
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (rsp_valid) begin
                got       = 1'b1;
                got_rdata = rsp_rdata;
                got_err   = rsp_err;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (emio_ps_out !== 64'h0) begin
            errors++;
            $display("FAIL reset_out got %h want %h", emio_ps_out, 64'h0);
        end
        checks++;
        if (emio_ps_tri !== {32'h0, 32'hFFFF_FFFF}) begin
            errors++;
            $display("FAIL reset_tri got %h want %h", emio_ps_tri, {32'h0, 32'hFFFF_FFFF});
        end
        checks++;
        if ({cmd_ready, rsp_valid, rsp_err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctl got %b want 000", {cmd_ready, rsp_valid, rsp_err});
        end
        checks++;
        if (rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata got %h want 0", rsp_rdata);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b want 1", cmd_ready);
        end
    endtask

    task automatic test_read();
        bit   got;
        int   n;
        exp_t e;
        resp_delay = 2;
        resp_data  = 32'hDEAD_BEEF;
        sb.push_back('{rdata: 32'hDEAD_BEEF, err: 1'b0, chk_data: 1'b1});
        send_cmd(1'b0, 16'h0010, 32'h0, 1'b0, 1'b0);
        checks++;
        if (emio_ps_tri[31:0] !== 32'hFFFF_FFFF || emio_ps_out[47:32] !== 16'h0010) begin
            errors++;
            $display("FAIL read_drive got tri %h addr %h want tri FFFFFFFF addr 0010",
                     emio_ps_tri[31:0], emio_ps_out[47:32]);
        end
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (req_bus) begin
                n = i;
                break;
            end
        end
        checks++;
        if (n != SetupCycles + 1) begin
            errors++;
            $display("FAIL read_latency got %0d want %0d", n, SetupCycles + 1);
        end
        wait_rsp(got);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL read_rsp got none want rsp_valid");
        end else begin
            e = sb.pop_front();
            if (got_rdata !== e.rdata || got_err !== e.err) begin
                errors++;
                $display("FAIL read_data got %h err %b want %h err %b",
                         got_rdata, got_err, e.rdata, e.err);
            end
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL read_strobe got valid %b ready %b want valid 0 ready 1",
                     rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_write();
        bit   seen_req;
        int   pre;
        int   wen_bad;
        int   chg;
        bit   got;
        exp_t e;
        sb.push_back('{rdata: 32'h0, err: 1'b0, chk_data: 1'b0});
        send_cmd(1'b1, 16'h0004, 32'h1234_5678, 1'b0, 1'b0);
        seen_req = 1'b0;
        pre = 0;
        wen_bad = 0;
        chg = 0;
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (rsp_valid) begin
                got = 1'b1;
                got_err = rsp_err;
                break;
            end
            if (reg_wen !== req_bus) wen_bad++;
            if (emio_ps_out[47:0] !== {16'h0004, 32'h1234_5678} || emio_ps_tri !== 64'h0) chg++;
            if (req_bus) seen_req = 1'b1;
            else if (!seen_req) pre++;
            tick();
        end
        checks++;
        if (pre < int'(SetupCycles) || !seen_req) begin
            errors++;
            $display("FAIL write_setup got %0d req %b want >= %0d req 1", pre, seen_req,
                     SetupCycles);
        end
        checks++;
        if (wen_bad != 0) begin
            errors++;
            $display("FAIL write_wen_align got %0d mismatched cycles want 0", wen_bad);
        end
        checks++;
        if (chg != 0) begin
            errors++;
            $display("FAIL write_stable got %0d bad cycles want 0", chg);
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL write_rsp got none want rsp_valid");
        end else begin
            e = sb.pop_front();
            if (got_err !== e.err) begin
                errors++;
                $display("FAIL write_err got %b want %b", got_err, e.err);
            end
        end
        tick();
    endtask

    task automatic test_timeout();
        int   n;
        bit   got;
        exp_t e;
        resp_enable = 1'b0;
        sb.push_back('{rdata: 32'h0, err: 1'b1, chk_data: 1'b0});
        send_cmd(1'b0, 16'h0020, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 20 && !req_bus; i++) tick();
        n = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            n++;
            if (!req_bus) break;
        end
        checks++;
        if (n != TimeoutCycles) begin
            errors++;
            $display("FAIL timeout_len got %0d want %0d", n, TimeoutCycles);
        end
        wait_rsp(got);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL timeout_rsp got none want rsp_valid");
        end else begin
            e = sb.pop_front();
            if (got_err !== e.err) begin
                errors++;
                $display("FAIL timeout_err got %b want %b", got_err, e.err);
            end
        end
        tick();
        resp_enable = 1'b1;
    endtask

    task automatic test_reset_mid();
        int seen;
        resp_enable = 1'b0;
        send_cmd(1'b1, 16'h0030, 32'hCAFE_F00D, 1'b0, 1'b0);
        for (int i = 0; i < 20 && !req_bus; i++) tick();
        reset = 1'b1;
        tick();
        checks++;
        if (emio_ps_out !== 64'h0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_out got %h valid %b want 0 valid 0", emio_ps_out, rsp_valid);
        end
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rsp_valid) seen++;
        end
        checks++;
        if (seen != 0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_rsp got %0d strobes ready %b want 0 ready 1", seen,
                     cmd_ready);
        end
        resp_enable = 1'b1;
    endtask

    task automatic test_back_to_back();
        bit          got;
        bit          wr;
        logic [15:0] a;
        logic [31:0] d;
        exp_t        e;
        for (int i = 0; i < 6; i++) begin
            wr = (i % 2) == 1;
            a  = 16'($urandom);
            d  = $urandom;
            resp_delay = (i % 3) * 2;
            resp_data  = d;
            sb.push_back('{rdata: d, err: 1'b0, chk_data: !wr});
            send_cmd(wr, a, d, 1'b0, 1'b0);
            wait_rsp(got);
            checks++;
            if (!got) begin
                errors++;
                $display("FAIL b2b_rsp[%0d] got none want rsp_valid", i);
            end else begin
                e = sb.pop_front();
                if (got_err !== e.err || cmd_ready !== 1'b0 ||
                    (e.chk_data && got_rdata !== e.rdata)) begin
                    errors++;
                    $display("FAIL b2b_data[%0d] got %h err %b ready %b want %h err %b ready 0",
                             i, got_rdata, got_err, cmd_ready, e.rdata, e.err);
                end
            end
            tick();
        end
    endtask

`ifdef EMIO_MASTER_BLKWR_EN
    task automatic test_block();
        logic [31:0] words[3];
        bit          got;
        bit          prev_wen;
        int          pulses;
        int          req_low;
        int          rsps;
        bit          opened;
        exp_t        e;
        words[0] = 32'hA;
        words[1] = 32'hB;
        words[2] = 32'hC;
        pulses = 0;
        req_low = 0;
        rsps = 0;
        opened = 1'b0;
        prev_wen = 1'b0;
        resp_delay = 1;
        for (int w = 0; w < 3; w++) begin
            sb.push_back('{rdata: 32'h0, err: 1'b0, chk_data: 1'b0});
            send_cmd(1'b1, 16'h0100, words[w], w == 0, w == 2);
            got = 1'b0;
            for (int i = 0; i < 300; i++) begin
                if (rsp_valid) begin
                    got = 1'b1;
                    got_err = rsp_err;
                    break;
                end
                if (blk_wen && !prev_wen) pulses++;
                prev_wen = blk_wen;
                if (req_bus) opened = 1'b1;
                else if (opened) req_low++;
                tick();
            end
            if (got) begin
                rsps++;
                e = sb.pop_front();
                checks++;
                if (got_err !== e.err) begin
                    errors++;
                    $display("FAIL blk_err[%0d] got %b want %b", w, got_err, e.err);
                end
            end
            tick();
        end
        checks++;
        if (pulses != 3 || rsps != 3 || req_low != 0) begin
            errors++;
            $display("FAIL blk_seq got pulses %0d rsps %0d req_low %0d want 3 3 0",
                     pulses, rsps, req_low);
        end
        checks++;
        if (req_bus !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL blk_close got req %b ready %b want req 0 ready 1", req_bus, cmd_ready);
        end
    endtask

    task automatic test_blk_illegal();
        bit got;
        send_cmd(1'b1, 16'h0200, 32'h1, 1'b1, 1'b0);
        wait_rsp(got);
        tick();
        send_cmd(1'b0, 16'h0204, 32'h0, 1'b0, 1'b0);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || req_bus !== 1'b1) begin
            errors++;
            $display("FAIL blk_illegal got valid %b err %b req %b want 1 1 1",
                     rsp_valid, rsp_err, req_bus);
        end
        tick();
        send_cmd(1'b1, 16'h0208, 32'h2, 1'b0, 1'b1);
        wait_rsp(got);
        checks++;
        if (!got || got_err !== 1'b0) begin
            errors++;
            $display("FAIL blk_after_illegal got rsp %b err %b want rsp 1 err 0", got, got_err);
        end
        tick();
        checks++;
        if (req_bus !== 1'b0) begin
            errors++;
            $display("FAIL blk_illegal_close got req %b want 0", req_bus);
        end
    endtask
`endif

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog got no finish want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        reset         = 1'b1;
        cmd_valid     = 1'b0;
        cmd_write     = 1'b0;
        cmd_addr      = '0;
        cmd_wdata     = '0;
        cmd_blk_first = 1'b0;
        cmd_blk_last  = 1'b0;
        test_reset();
        test_read();
        test_write();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
`ifdef EMIO_MASTER_BLKWR_EN
        test_block();
        test_blk_illegal();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
